// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and lane helpers for the load/store unit
package mips_cpu_pkg;

  // Memory operation codes; bit 3 marks a store.
  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LBU = 4'b0001,
    LH  = 4'b0010,
    LHU = 4'b0011,
    LW  = 4'b0100,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } typeLsuOp;

  typedef enum logic [2:0] {
    LSU_IDLE    = 3'd0,
    LSU_BUS_RD  = 3'd1,
    LSU_BUS_WR  = 3'd2,
    LSU_CAPTURE = 3'd3,
    LSU_RESP    = 3'd4
  } typeLsuState;

  // Any encoding outside the defined set behaves as a word load.
  function automatic typeLsuOp lsu_normalize_op(input logic [3:0] raw);
    case (raw)
      4'b0000: return LB;
      4'b0001: return LBU;
      4'b0010: return LH;
      4'b0011: return LHU;
      4'b1000: return SB;
      4'b1001: return SH;
      4'b1010: return SW;
      default: return LW;
    endcase
  endfunction

  function automatic logic lsu_is_store(input typeLsuOp op);
    return op[3];
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic lsu_misaligned(input typeLsuOp op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Little-endian lanes: byte offset k drives byteenable[k]. Halfwords key off
  // addr[1] only so that unchecked misaligned accesses still hit a legal pair.
  function automatic logic [3:0] lsu_byteenable(input typeLsuOp op, input logic [1:0] off);
    case (op)
      LB, LBU, SB: return 4'b0001 << off;
      LH, LHU, SH: return off[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes; byteenable picks the live one.
  function automatic logic [31:0] lsu_writedata(input typeLsuOp op, input logic [31:0] wdata);
    case (op)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_format.sv
// rtl/mips_cpu_lsu_format.sv - load lane extraction and sign/zero extension
module mips_cpu_lsu_format
  import mips_cpu_pkg::*;
(
  input  typeLsuOp    op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] readdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword and extend it to a register-width result.
  always_comb begin
    byte_lane = readdata_i[7:0];
    half_lane = offset_i[1] ? readdata_i[31:16] : readdata_i[15:0];
    case (offset_i)
      2'd0: byte_lane = readdata_i[7:0];
      2'd1: byte_lane = readdata_i[15:8];
      2'd2: byte_lane = readdata_i[23:16];
      2'd3: byte_lane = readdata_i[31:24];
      default: byte_lane = readdata_i[7:0];
    endcase
    result_o = readdata_i;
    case (op_i)
      LB:      result_o = {{24{byte_lane[7]}}, byte_lane};
      LBU:     result_o = {24'h000000, byte_lane};
      LH:      result_o = {{16{half_lane[15]}}, half_lane};
      LHU:     result_o = {16'h0000, half_lane};
      default: result_o = readdata_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// rtl/mips_cpu_lsu.sv - load/store unit bridging execute requests to Avalon-MM
module mips_cpu_lsu
  import mips_cpu_pkg::*;
#(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typeLsuState state_q, state_d;
  typeLsuOp    op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  typeLsuOp    req_op_n;
  logic [31:0] fmt_result;

  assign req_op_n = lsu_normalize_op(req_op);
  assign rsp_data = rsp_data_q;

  mips_cpu_lsu_format u_format (
    .op_i       (op_q),
    .offset_i   (addr_q[1:0]),
    .readdata_i (readdata),
    .result_o   (fmt_result)
  );

  // State and latched request registers; reset drops any in-flight bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      op_q       <= LW;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rsp_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state and output decode; bus outputs come only from latched registers.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'h0;
    writedata  = 32'h0;
    byteenable = 4'b0000;
    case (state_q)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op_n;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          if ((ALIGN_CHECK != 0) && lsu_misaligned(req_op_n, req_addr[1:0])) begin
            err_d      = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = LSU_RESP;
          end else if (lsu_is_store(req_op_n)) begin
            state_d = LSU_BUS_WR;
          end else begin
            state_d = LSU_BUS_RD;
          end
        end
      end
      LSU_BUS_RD: begin
        read       = 1'b1;
        address    = {addr_q[31:2], 2'b00};
        byteenable = lsu_byteenable(op_q, addr_q[1:0]);
        if (!waitrequest) begin
          state_d = LSU_CAPTURE;
        end
      end
      LSU_BUS_WR: begin
        write      = 1'b1;
        address    = {addr_q[31:2], 2'b00};
        byteenable = lsu_byteenable(op_q, addr_q[1:0]);
        writedata  = lsu_writedata(op_q, wdata_q);
        if (!waitrequest) begin
          rsp_data_d = 32'h0;
          state_d    = LSU_RESP;
        end
      end
      LSU_CAPTURE: begin
        rsp_data_d = fmt_result;
        state_d    = LSU_RESP;
      end
      LSU_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb/tb_mips_cpu_lsu.sv - self-checking bench for the load/store unit
module tb_mips_cpu_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mips_cpu_lsu #(.ALIGN_CHECK(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, play an Avalon slave with a given stall count, and
  // compare everything against expectations derived from size/sign/offset.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits);
    int          size;
    bit          sgn;
    bit          st;
    bit          mis;
    int          k;
    int          cyc;
    int          bus;
    bit          got;
    bit          rd_next;
    logic [31:0] mask;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_res;
    logic [31:0] v;
    int          exp_lat;
    int          exp_bus;

    sgn = 1'b0;
    st  = 1'b0;
    case (op)
      4'd0:    begin size = 1; sgn = 1'b1; end
      4'd1:    begin size = 1; end
      4'd2:    begin size = 2; sgn = 1'b1; end
      4'd3:    begin size = 2; end
      4'd8:    begin size = 1; st = 1'b1; end
      4'd9:    begin size = 2; st = 1'b1; end
      4'd10:   begin size = 4; st = 1'b1; end
      default: begin size = 4; end
    endcase
    k    = int'(addr[1:0]);
    mis  = (k % size) != 0;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    exp_be = ((32'd1 << size) - 32'd1) << k;
    exp_wd = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
             (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    v = (rdata >> (8 * k)) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;
    exp_res = (st || mis) ? 32'h0 : v;
    exp_lat = mis ? 1 : (st ? 2 + waits : 3 + waits);
    exp_bus = mis ? 0 : waits + 1;

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_wdata   = wdata;
    waitrequest = 1'($urandom);
    readdata    = $urandom;
    rd_next = 1'b0;
    cyc = 0;
    bus = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'($urandom);
      req_op    = 4'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      readdata  = rd_next ? rdata : $urandom;
      rd_next   = 1'b0;
      if (read || write) begin
        bus++;
        check("bus_read", 32'(read), 32'(!st && !mis));
        check("bus_write", 32'(write), 32'(st && !mis));
        check("bus_address", address, {addr[31:2], 2'b00});
        check("bus_byteenable", 32'(byteenable), exp_be);
        if (st) check("bus_writedata", writedata, exp_wd);
        waitrequest = (bus <= waits);
        if (!waitrequest && read) rd_next = 1'b1;
      end else begin
        check("bus_quiet", address | writedata | 32'(byteenable), 32'h0);
        waitrequest = 1'($urandom);
      end
      if (rsp_valid) begin
        got = 1'b1;
        check("rsp_latency", 32'(cyc), 32'(exp_lat));
        check("rsp_data", rsp_data, exp_res);
        check("rsp_err", 32'(rsp_err), 32'(mis));
        check("bus_cycles", 32'(bus), 32'(exp_bus));
        check("ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
    req_valid = 1'b0;
    check("rsp_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check("rsp_data_hold", rsp_data, exp_res);
  endtask

  logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hF};

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 4'h0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rw", 32'({read, write}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_byteenable", 32'(byteenable), 32'h0);
    reset = 1'b0;

    run_op(4'h4, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    run_op(4'h0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    run_op(4'h1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    run_op(4'h9, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
    run_op(4'h4, 32'h0000_1001, 32'h0, 32'h1234_5678, 0);
    run_op(4'h8, 32'h0000_3001, 32'h1234_56A5, 32'h0, 1);
    run_op(4'h2, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 2);
    run_op(4'hA, 32'h0000_3006, 32'h5555_AAAA, 32'h0, 0);
    run_op(4'hD, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 1);

    @(negedge clk);
    req_valid   = 1'b1;
    req_op      = 4'h4;
    req_addr    = 32'h0000_1000;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("stall_read", 32'(read), 32'd1);
    @(negedge clk);
    check("stall_read_held", 32'(read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_read", 32'(read), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_address", address | 32'(byteenable), 32'h0);
    reset       = 1'b0;
    waitrequest = 1'b0;
    run_op(4'h3, 32'h0000_1002, 32'h0, 32'h9ABC_0000, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
